pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
Parametrised multi-stage pipeline register with per-stage valid tracking, stall (enable), synchronous flush and an occupancy count. It generalises the fixed 34-bit single-stage register bank to WIDTH bits by DEPTH stages, adding reset, enable and flush. It is used to align systolic-array operands and results, for example the row/column skew delays and accumulator output staging.

Parameters:
WIDTH, 34, data bits per stage (>=1)
DEPTH, 4, number of register stages, i.e. latency in enabled cycles (>=1)
OCW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
C  input  1  clock; all state updates on rising edge
Rn  input  1  asynchronous active-low reset
EN  input  1  advance enable; 0 = stall, all stages hold
CLR  input  1  synchronous flush; clears valid bits, data and count
VIN  input  1  input valid
D  input  WIDTH  input data
VOUT  output  1  valid bit of stage DEPTH-1
Q  output  WIDTH  data of stage DEPTH-1
OCC  output  OCW  number of stages currently holding valid=1

Behaviour:
- Reset: asynchronous on Rn=0, independent of C. Every stage's data and valid bit go to 0; OCC=0, VOUT=0, Q=0. Registers hold at reset while Rn=0. First update is the first rising C edge after Rn goes to 1.
- Stage state: v[i] and d[i] for i=0..DEPTH-1. Outputs come directly from stage DEPTH-1, with no combinational path from D/VIN to Q/VOUT.
- Priority per rising edge: Rn=0, then CLR, then EN, then hold.
- CLR=1 (EN ignored): all v[i]=0, all d[i]=0, OCC=0. VIN/D on that cycle are discarded.
- EN=1, CLR=0: v[0]<=VIN, d[0]<=D; v[i]<=v[i-1], d[i]<=d[i-1] for i>=1. D is captured even when VIN=0, so Q is raw data and is meaningful only when VOUT=1.
- EN=0, CLR=0: all stages and OCC hold. VIN/D are ignored and not buffered, so no backpressure output exists. Upstream must hold off or accept the loss.
- Latency: a word presented with EN=1 at edge k appears on Q/VOUT after edge k+DEPTH-1. That is DEPTH enabled edges counting capture, with stall cycles adding 1:1.
- OCC: registered. On an EN edge, OCC<=OCC+VIN-v[DEPTH-1]; a simultaneous enter and exit leaves it unchanged. OCC never exceeds DEPTH and never underflows. The invariant OCC == popcount(v) must hold after every edge.
- DEPTH=1: a single stage; OCC is 1 bit and equals VOUT.
- Bubbles (VIN=0) propagate as ordinary stages and are never compressed.
- Reset asserted mid-stream: all in-flight words are lost. No partial state survives.
- Structure: each stage is built from the codebase's edge-triggered flip-flop cell extended with an active-low async clear. The enable is implemented as a D-input mux (hold path), with no clock gating.

Test Plan:
- Reset: drive D=34'h3FFFFFFFF, VIN=1, EN=1, Rn=0 across 3 edges, then release -> Q=0, VOUT=0, OCC=0 throughout reset. Assert Rn=0 between edges -> outputs clear immediately, not at the next edge.
- Latency (DEPTH=4): EN=1; VIN=1 with D=1,2,3,4,5 on consecutive edges, then VIN=0 -> Q/VOUT show 1..5 with VOUT=1 starting after the 4th edge. OCC ramps 1,2,3,4, holds at 4, then falls to 0 as VIN=0 drains.
- Stall: load D=0xA,0xB,0xC, then EN=0 for 5 edges while toggling D/VIN -> Q, VOUT and OCC frozen. Resume with EN=1 -> 0xA emerges exactly 5 edges later than without the stall, and the toggled inputs never appear.
- Flush: pipe full (OCC=4), assert CLR=1 with EN=0 and VIN=1, D=0x55 -> next edge OCC=0, VOUT=0, Q=0, and 0x55 never appears. CLR with EN=1 gives the identical result.
- Bubbles: VIN pattern 1,0,1,1,0 with D=0x10..0x14 -> VOUT pattern 1,0,1,1,0 appears DEPTH-1 edges later with Q=0x10,0x11(raw),0x12,0x13,0x14(raw). OCC equals popcount(v) on every edge.
- Parameter sweep (WIDTH=1/DEPTH=1 and WIDTH=64/DEPTH=8): random VIN/EN/CLR/D over 10k cycles against a queue model -> Q/VOUT/OCC match the model every cycle.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//
// Parametrised WIDTH x DEPTH pipeline register with a valid bit per stage,
// stall (EN), synchronous flush (CLR) and a registered occupancy count.
// Used to align systolic-array operands and results (row/column skew delays,
// accumulator output staging).
//
// Ports:
//   C     in   1      clock, all state updates on the rising edge
//   Rn    in   1      asynchronous active-low reset
//   EN    in   1      advance enable; 0 = every stage holds
//   CLR   in   1      synchronous flush of valid bits, data and count
//   VIN   in   1      input valid
//   D     in   WIDTH  input data (captured on every EN edge, even if VIN=0)
//   VOUT  out  1      valid bit of the last stage
//   Q     out  WIDTH  data of the last stage (meaningful only when VOUT=1)
//   OCC   out  OCW    number of stages currently holding valid=1
//
// Edge priority: Rn low, then CLR, then EN, then hold. Q/VOUT/OCC come
// straight from flops; there is no combinational path from D/VIN to outputs.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pipe_reg_dffr
//
// Edge-triggered flip-flop cell with an active-low asynchronous clear.
// Ports: clk (clock), rst_n (async clear, active low), d (next value),
//        q (registered value).
// ---------------------------------------------------------------------------
module pipe_reg_dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage element: clears immediately on rst_n low, else follows d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

module pipe_reg_chain #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    parameter int OCW   = $clog2(DEPTH + 1)
) (
    input  logic             C,
    input  logic             Rn,
    input  logic             EN,
    input  logic             CLR,
    input  logic             VIN,
    input  logic [WIDTH-1:0] D,
    output logic             VOUT,
    output logic [WIDTH-1:0] Q,
    output logic [OCW-1:0]   OCC
);

    // Stage state: index 0 is the entry stage, DEPTH-1 drives the outputs.
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0]            valid_q;
    logic [OCW-1:0]              occ_d;
    logic [OCW-1:0]              occ_q;

    // Occupancy update for one advance: +1 when a valid word enters, -1 when
    // a valid word leaves the last stage, unchanged when both or neither.
    // The count is bounded by construction: it tracks the valid bits exactly,
    // so it can never exceed DEPTH or drop below zero.
    function automatic logic [OCW-1:0] occ_next(
        input logic [OCW-1:0] occ_cur,
        input logic           enter,
        input logic           leave
    );
        logic [OCW-1:0] occ_res;
        case ({enter, leave})
            2'b10:   occ_res = occ_cur + OCW'(1);
            2'b01:   occ_res = occ_cur - OCW'(1);
            default: occ_res = occ_cur;
        endcase
        return occ_res;
    endfunction

    // Next-state mux: flush, advance, or hold (the hold path replaces any
    // clock gating, so every flop is clocked every cycle).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;
        if (CLR) begin
            // Flush wins over EN; the word on VIN/D this cycle is dropped.
            data_d  = {(DEPTH * WIDTH){1'b0}};
            valid_d = {DEPTH{1'b0}};
            occ_d   = {OCW{1'b0}};
        end else if (EN) begin
            // Raw data shifts with its valid bit; bubbles keep their slot.
            data_d[0]  = D;
            valid_d[0] = VIN;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            occ_d = occ_next(occ_q, VIN, valid_q[DEPTH-1]);
        end else begin
            // Stall: inputs are ignored and nothing is buffered.
            data_d  = data_q;
            valid_d = valid_q;
            occ_d   = occ_q;
        end
    end

    // One data cell and one valid cell per stage.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_reg_dffr #(.W(WIDTH)) u_data (
            .clk   (C),
            .rst_n (Rn),
            .d     (data_d[g]),
            .q     (data_q[g])
        );

        pipe_reg_dffr #(.W(1)) u_valid (
            .clk   (C),
            .rst_n (Rn),
            .d     (valid_d[g]),
            .q     (valid_q[g])
        );
    end

    // Occupancy counter register.
    pipe_reg_dffr #(.W(OCW)) u_occ (
        .clk   (C),
        .rst_n (Rn),
        .d     (occ_d),
        .q     (occ_q)
    );

    assign Q    = data_q[DEPTH-1];
    assign VOUT = valid_q[DEPTH-1];
    assign OCC  = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain
//
// Drives three pipe_reg_chain instances (34x4, 1x1, 64x8) with shared
// stimulus. The reference keeps, per instance, the list of words accepted
// since the last reset/flush: the output is the word accepted DEPTH
// advances ago, and the occupancy is the number of valid words among the
// last DEPTH accepted.
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rn;
    logic        en;
    logic        clr;
    logic        vin;
    logic [63:0] d_in;

    logic        vout0;
    logic        vout1;
    logic        vout2;
    logic [33:0] q0;
    logic [0:0]  q1;
    logic [63:0] q2;
    logic [2:0]  occ0;
    logic [0:0]  occ1;
    logic [3:0]  occ2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } ent_t;

    ent_t        hist [3][$];
    int          dep  [3] = '{4, 1, 8};
    logic [63:0] msk  [3] = '{64'h0000_0003_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(34), .DEPTH(4)) u_dut0 (
        .C(clk), .Rn(rn), .EN(en), .CLR(clr), .VIN(vin), .D(d_in[33:0]),
        .VOUT(vout0), .Q(q0), .OCC(occ0)
    );

    pipe_reg_chain #(.WIDTH(1), .DEPTH(1)) u_dut1 (
        .C(clk), .Rn(rn), .EN(en), .CLR(clr), .VIN(vin), .D(d_in[0:0]),
        .VOUT(vout1), .Q(q1), .OCC(occ1)
    );

    pipe_reg_chain #(.WIDTH(64), .DEPTH(8)) u_dut2 (
        .C(clk), .Rn(rn), .EN(en), .CLR(clr), .VIN(vin), .D(d_in),
        .VOUT(vout2), .Q(q2), .OCC(occ2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference reaction to a rising edge, using the inputs held across it.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rn || clr) begin
                hist[k].delete();
            end else if (en) begin
                hist[k].push_back('{v: vin, d: d_in & msk[k]});
                while (hist[k].size() > dep[k]) begin
                    void'(hist[k].pop_front());
                end
            end
        end
    endtask

    task automatic model_async_reset();
        for (int k = 0; k < 3; k++) begin
            hist[k].delete();
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            logic        ev;
            logic [63:0] ed;
            int          eo;
            ev = 1'b0;
            ed = 64'h0;
            eo = 0;
            if (hist[k].size() >= dep[k]) begin
                ev = hist[k][0].v;
                ed = hist[k][0].d;
            end
            for (int j = 0; j < hist[k].size(); j++) begin
                if (hist[k][j].v) eo++;
            end
            case (k)
                0: begin
                    check_val({tag, "_v0"}, {63'h0, vout0}, {63'h0, ev});
                    check_val({tag, "_q0"}, {30'h0, q0}, ed);
                    check_val({tag, "_o0"}, {61'h0, occ0}, 64'(eo));
                end
                1: begin
                    check_val({tag, "_v1"}, {63'h0, vout1}, {63'h0, ev});
                    check_val({tag, "_q1"}, {63'h0, q1}, ed);
                    check_val({tag, "_o1"}, {63'h0, occ1}, 64'(eo));
                end
                default: begin
                    check_val({tag, "_v2"}, {63'h0, vout2}, {63'h0, ev});
                    check_val({tag, "_q2"}, q2, ed);
                    check_val({tag, "_o2"}, {60'h0, occ2}, 64'(eo));
                end
            endcase
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    // Pulse Rn low between edges and verify outputs clear before any edge.
    task automatic async_reset_pulse(input string tag);
        #2;
        rn = 1'b0;
        #1;
        model_async_reset();
        check_all(tag);
        check_val({tag, "_q"}, {30'h0, q0}, 64'h0);
        check_val({tag, "_occ"}, {61'h0, occ0}, 64'h0);
        rn = 1'b1;
    endtask

    initial begin
        int exp_occ [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
        logic bub_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held across edges with all inputs active.
        rn   = 1'b0;
        en   = 1'b1;
        clr  = 1'b0;
        vin  = 1'b1;
        d_in = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            tick("rst_hold");
            check_val("rst_q", {30'h0, q0}, 64'h0);
            check_val("rst_v", {63'h0, vout0}, 64'h0);
        end
        rn = 1'b1;

        // Latency: 1..5 then bubbles.
        for (int e = 1; e <= 9; e++) begin
            vin  = (e <= 5);
            d_in = (e <= 5) ? 64'(e) : 64'h0;
            tick("lat");
            check_val("lat_occ", {61'h0, occ0}, 64'(exp_occ[e-1]));
            if (e >= 4 && e <= 8) begin
                check_val("lat_q", {30'h0, q0}, 64'(e - 3));
                check_val("lat_v", {63'h0, vout0}, 64'h1);
            end else begin
                check_val("lat_v", {63'h0, vout0}, 64'h0);
            end
        end

        // Stall: load A,B,C, freeze 5 edges with toggling inputs, resume.
        clr = 1'b1;
        tick("stl_clr");
        clr = 1'b0;
        vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = 64'hA + 64'(i);
            tick("stl_load");
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vin  = 1'($urandom_range(0, 1));
            d_in = {$urandom, $urandom};
            tick("stl_hold");
            check_val("stl_occ", {61'h0, occ0}, 64'h3);
            check_val("stl_v", {63'h0, vout0}, 64'h0);
        end
        en   = 1'b1;
        vin  = 1'b0;
        d_in = 64'h0;
        for (int i = 0; i < 4; i++) begin
            tick("stl_res");
            check_val("stl_q", {30'h0, q0}, (i < 3) ? 64'hA + 64'(i) : 64'h0);
            check_val("stl_v", {63'h0, vout0}, (i < 3) ? 64'h1 : 64'h0);
        end

        // Flush from full, with EN low then EN high.
        for (int mode = 0; mode < 2; mode++) begin
            en  = 1'b1;
            vin = 1'b1;
            for (int i = 0; i < 4; i++) begin
                d_in = 64'h100 + 64'(i);
                tick("fl_fill");
            end
            check_val("fl_full", {61'h0, occ0}, 64'h4);
            clr  = 1'b1;
            en   = (mode == 1);
            d_in = 64'h55;
            tick("fl_clr");
            check_val("fl_occ", {61'h0, occ0}, 64'h0);
            check_val("fl_v", {63'h0, vout0}, 64'h0);
            check_val("fl_q", {30'h0, q0}, 64'h0);
            clr  = 1'b0;
            en   = 1'b1;
            vin  = 1'b0;
            d_in = 64'h0;
            repeat (4) begin
                tick("fl_drain");
                check_val("fl_no55", {30'h0, q0}, 64'h0);
            end
        end

        // Bubbles keep their slots; raw data still moves.
        for (int e = 1; e <= 9; e++) begin
            vin  = (e <= 5) ? bub_v[e-1] : 1'b0;
            d_in = (e <= 5) ? 64'h10 + 64'(e - 1) : 64'h0;
            tick("bub");
            if (e >= 4 && e <= 8) begin
                check_val("bub_v", {63'h0, vout0}, {63'h0, bub_v[e-4]});
                check_val("bub_q", {30'h0, q0}, 64'h10 + 64'(e - 4));
            end
        end

        // Reset asserted mid-stream.
        vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = 64'h200 + 64'(i);
            tick("mid_fill");
        end
        async_reset_pulse("mid_rst");
        tick("mid_after");

        // Randomised run across all three configurations.
        for (int c = 0; c < 10000; c++) begin
            en   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            vin  = 1'($urandom_range(0, 1));
            d_in = {$urandom, $urandom};
            tick("rnd");
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse("rnd_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
